// File: rtl/rom_arb_pkg.sv
// ============================================================================
// Module      : rom_arb_pkg
// Description : Shared types and constants for the two-port ROM arbiter.
//               Holds the FSM state encoding and the requester port ids.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_arb_pkg;

    // Arbiter FSM states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Requester identifiers
    localparam logic PORT_FETCH = 1'b0;  // instruction fetch unit
    localparam logic PORT_LOAD  = 1'b1;  // data load unit

    // One-hot grant vector for a given port id
    function automatic logic [1:0] port_onehot(input logic id);
        return (id == PORT_LOAD) ? 2'b10 : 2'b01;
    endfunction

endpackage : rom_arb_pkg

`default_nettype wire

// File: rtl/rom_arb_pick.sv
// ============================================================================
// Module      : rom_arb_pick
// Description : Two-input request selector. Turns the request pair into a
//               one-hot grant. When both ports request, the winner depends
//               on the build:
//                 ROM_ARB_RR_EN defined   -> port named by ptr_i wins
//                 ROM_ARB_RR_EN undefined -> port 0 always wins (ptr_i unused)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arb_pick
    import rom_arb_pkg::*;
(
    input  logic [1:0] req_i,   // {req1, req0}
    input  logic       ptr_i,   // preferred port on contention
    output logic [1:0] gnt_o    // one-hot grant, zero when no request
);

`ifndef ROM_ARB_RR_EN
    // Fixed priority ignores the pointer; keep it visibly sunk
    logic w_unused_ptr;
    assign w_unused_ptr = ptr_i;
`endif

    // Resolve the request pair into at most one grant
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
`ifdef ROM_ARB_RR_EN
            gnt_o = port_onehot(ptr_i);
`else
            gnt_o = port_onehot(PORT_FETCH);
`endif
        end else begin
            // Zero or one requester: pass straight through
            gnt_o = req_i;
        end
    end

endmodule : rom_arb_pick

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module      : rom_arbiter
// Description : Shares one combinational ROM between an instruction-fetch
//               port (0) and a data-load port (1). One access in flight at a
//               time: grant (IDLE/RESP) -> ROM address (ACCESS) -> response
//               with a one-cycle rvalid (RESP). A new grant may overlap the
//               response cycle, giving one response every two cycles.
//               Build option: ROM_ARB_RR_EN selects round-robin arbitration;
//               without it port 0 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    // Port 0: instruction fetch
    input  logic                  req0_i,
    input  logic [ADDR_WIDTH-1:0] addr0_i,
    output logic                  gnt0_o,
    output logic                  rvalid0_o,
    output logic [DATA_WIDTH-1:0] rdata0_o,

    // Port 1: data load
    input  logic                  req1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    output logic                  gnt1_o,
    output logic                  rvalid1_o,
    output logic [DATA_WIDTH-1:0] rdata1_o,

    // ROM side
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i
);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                  state_q,   state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic                    win_q,     win_d;
    logic                    rvalid0_q, rvalid0_d;
    logic                    rvalid1_q, rvalid1_d;

    logic                    w_grant_ok;
    logic [1:0]              w_pick;
    logic [1:0]              w_gnt;
    logic                    w_win_id;
    logic                    w_ptr;

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // Grants are only possible when no access is being driven to the ROM and
    // never while reset is asserted, so gnt reads 0 throughout reset.
    assign w_grant_ok = !rst_i && ((state_q == IDLE) || (state_q == RESP));

    rom_arb_pick u_pick (
        .req_i ({req1_i, req0_i}),
        .ptr_i (w_ptr),
        .gnt_o (w_pick)
    );

    assign w_gnt    = w_grant_ok ? w_pick : 2'b00;
    assign w_win_id = w_gnt[1] ? PORT_LOAD : PORT_FETCH;
    assign gnt0_o   = w_gnt[0];
    assign gnt1_o   = w_gnt[1];

`ifdef ROM_ARB_RR_EN
    logic ptr_q, ptr_d;

    // Pointer moves to the port that lost (or did not request) after a grant
    always_comb begin
        ptr_d = ptr_q;
        if (w_gnt != 2'b00) begin
            ptr_d = ~w_win_id;
        end
    end

    // Round-robin pointer register; reset favours the fetch port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= PORT_FETCH;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign w_ptr = ptr_q;
`else
    assign w_ptr = PORT_FETCH;
`endif

    // ------------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------------
    // FSM transitions plus address/winner capture on grant and ROM-word
    // capture in ACCESS; rvalid is raised for exactly the RESP cycle.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        win_d     = win_q;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;

        unique case (state_q)
            IDLE, RESP: begin
                if (w_gnt != 2'b00) begin
                    addr_d  = w_gnt[1] ? addr1_i : addr0_i;
                    win_d   = w_win_id;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end

            ACCESS: begin
                data_d    = rom_data_i;
                rvalid0_d = (win_q == PORT_FETCH);
                rvalid1_d = (win_q == PORT_LOAD);
                state_d   = RESP;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered state; reset drops any in-flight access without a response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            win_q     <= PORT_FETCH;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            win_q     <= win_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // The address register holds its value outside ACCESS, so the ROM address
    // only changes when a new grant is taken.
    assign rom_addr_o = addr_q;
    assign rvalid0_o  = rvalid0_q;
    assign rvalid1_o  = rvalid1_q;
    assign rdata0_o   = data_q;
    assign rdata1_o   = data_q;

endmodule : rom_arbiter

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// ============================================================================
// Module      : tb_rom_arbiter
// Description : Self-checking bench for rom_arbiter. A behavioural ROM model
//               answers the DUT's address; a scoreboard queues the expected
//               response (port, word, due cycle) at each grant and checks it
//               when rvalid appears. Directed steps cover reset, single read,
//               contention, back-to-back reads, reset mid-access and a
//               request withdrawn before grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    rom_arbiter dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req0_i     (req0),
        .addr0_i    (addr0),
        .gnt0_o     (gnt0),
        .rvalid0_o  (rvalid0),
        .rdata0_o   (rdata0),
        .req1_i     (req1),
        .addr1_i    (addr1),
        .gnt1_o     (gnt1),
        .rvalid1_o  (rvalid1),
        .rdata1_o   (rdata1),
        .rom_addr_o (rom_addr),
        .rom_data_i (rom_data)
    );

    // ROM contents: one fixed word at 0x10, a scrambled pattern elsewhere
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return (a * 32'h0100_0193) ^ 32'hA5A5_0F0F;
    endfunction

    assign rom_data = rom_fn(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on grant, pop and compare on rvalid (sampled mid-cycle)
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (gnt0 && gnt1) chk("sb_double_grant", 32'({gnt1, gnt0}), 32'b01);
            if (gnt0) sb_q.push_back('{port: 1'b0, data: rom_fn(addr0), due: cyc + 2});
            else if (gnt1) sb_q.push_back('{port: 1'b1, data: rom_fn(addr1), due: cyc + 2});

            if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
                chk("sb_rvalid", 32'({rvalid1, rvalid0}), (sb_q[0].port ? 32'b10 : 32'b01));
                chk("sb_rdata", sb_q[0].port ? rdata1 : rdata0, sb_q[0].data);
                void'(sb_q.pop_front());
            end else if (rvalid0 || rvalid1) begin
                chk("sb_unexpected_rvalid", 32'({rvalid1, rvalid0}), 32'b00);
            end
        end
    end

    // Run-time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_p;

        // ---------------- reset with req0 held ----------------
        rst = 1'b1; req0 = 1'b1; addr0 = 32'h10; req1 = 1'b0; addr1 = 32'h0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt0",     32'(gnt0),     32'd0);
            chk("rst_gnt1",     32'(gnt1),     32'd0);
            chk("rst_rvalid0",  32'(rvalid0),  32'd0);
            chk("rst_rvalid1",  32'(rvalid1),  32'd0);
            chk("rst_rdata0",   rdata0,        32'h0);
            chk("rst_rdata1",   rdata1,        32'h0);
            chk("rst_rom_addr", rom_addr,      32'h0);
        end
        @(posedge clk); #1 rst = 1'b0;

        // ---------------- single port 0 read of 0x10 ----------------
        @(negedge clk);
        chk("p0_gnt_N", 32'(gnt0), 32'd1);
        chk("p0_gnt1_N", 32'(gnt1), 32'd0);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("p0_romaddr_N1", rom_addr, 32'h10);
        chk("p0_rvalid_N1", 32'(rvalid0), 32'd0);
        @(negedge clk);
        chk("p0_rvalid_N2", 32'(rvalid0), 32'd1);
        chk("p0_rdata_N2", rdata0, 32'hDEAD_BEEF);
        chk("p0_rvalid1_N2", 32'(rvalid1), 32'd0);
        @(negedge clk);
        chk("p0_rvalid_N3", 32'(rvalid0), 32'd0);
        chk("p0_romaddr_hold", rom_addr, 32'h10);

        // ---------------- contention (fresh pointer) ----------------
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        req0 = 1'b1; addr0 = 32'h4; req1 = 1'b1; addr1 = 32'h8;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
`ifdef ROM_ARB_RR_EN
                exp_p = (k / 2) % 2;
`else
                exp_p = 0;
`endif
                chk("cont_gnt0", 32'(gnt0), 32'(exp_p == 0));
                chk("cont_gnt1", 32'(gnt1), 32'(exp_p == 1));
            end else begin
                chk("cont_nogrant", 32'({gnt1, gnt0}), 32'b00);
            end
        end
        @(posedge clk); #1 req0 = 1'b0; req1 = 1'b0;
        repeat (3) @(negedge clk);

        // ---------------- back-to-back port 1 reads ----------------
        @(posedge clk); #1 req1 = 1'b1; addr1 = 32'h20;
        @(negedge clk);
        chk("b2b_gnt1_a", 32'(gnt1), 32'd1);
        @(posedge clk); #1 addr1 = 32'h24;
        @(negedge clk);
        chk("b2b_gnt1_access", 32'(gnt1), 32'd0);
        @(negedge clk);
        chk("b2b_gnt1_b", 32'(gnt1), 32'd1);
        chk("b2b_rvalid1_a", 32'(rvalid1), 32'd1);
        chk("b2b_rdata1_a", rdata1, rom_fn(32'h20));
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        chk("b2b_rvalid1_gap", 32'(rvalid1), 32'd0);
        @(negedge clk);
        chk("b2b_rvalid1_b", 32'(rvalid1), 32'd1);
        chk("b2b_rdata1_b", rdata1, rom_fn(32'h24));
        @(negedge clk);

        // ---------------- reset during ACCESS ----------------
        @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h30;
        @(negedge clk);
        chk("racc_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1 req0 = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("racc_rvalid_in_rst", 32'({rvalid1, rvalid0}), 32'b00);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("racc_rvalid_after", 32'({rvalid1, rvalid0}), 32'b00);
        @(negedge clk);
        chk("racc_rvalid_later", 32'({rvalid1, rvalid0}), 32'b00);
        @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h44;
        @(negedge clk);
        chk("racc_regnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1 req0 = 1'b0;
        @(negedge clk);
        chk("racc_romaddr", rom_addr, 32'h44);
        @(negedge clk);
        chk("racc_rvalid0", 32'(rvalid0), 32'd1);
        chk("racc_rdata0", rdata0, rom_fn(32'h44));

        // ---------------- port 1 pulse while port 0 in flight ----------------
        @(posedge clk); #1 req0 = 1'b1; addr0 = 32'h50;
        @(negedge clk);
        chk("pulse_gnt0", 32'(gnt0), 32'd1);
        @(posedge clk); #1 req0 = 1'b0; req1 = 1'b1; addr1 = 32'h60;
        @(negedge clk);
        chk("pulse_gnt1_access", 32'(gnt1), 32'd0);
        @(posedge clk); #1 req1 = 1'b0;
        @(negedge clk);
        chk("pulse_rvalid0", 32'(rvalid0), 32'd1);
        chk("pulse_gnt1_resp", 32'(gnt1), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("pulse_no_rvalid1", 32'(rvalid1), 32'd0);
            chk("pulse_no_gnt1", 32'(gnt1), 32'd0);
        end

        // ---------------- drain ----------------
        repeat (2) @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_rom_arbiter

`default_nettype wire
